fw_cmd_responder: RTL and testbench

FW_CMD_RESPONDER -- requirements
Module: fw_cmd_responder

---
 rtl/fw_cmd_responder.sv | 183 ++++++++++++++++++
 tb/tb_fw_cmd_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_cmd_responder.sv
// Firmware command responder: detects new {enable, op strobes, body} command words and
// runs config write/read, status and execute-countdown operations, with a registered status word.
module fw_cmd_responder #(
   parameter logic [23:0] CFG_STATIC_0_RST = 24'h000000,
   parameter logic [23:0] CFG_STATIC_1_RST = 24'h000000,
   parameter int          EXEC_CNT_W       = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fw_dev_id_enable,
   input  logic [14:0] fw_op_code_strobes,
   input  logic [23:0] sw_write24_0,
   output logic [31:0] fw_read_data32,
   output logic [31:0] fw_read_status32,
   output logic [23:0] fw_cfg_static_0,
   output logic [23:0] fw_cfg_static_1,
   output logic        fw_exec_busy,
   output logic        fw_exec_done
);

   typedef enum logic [3:0] {IDLE = 4'd0, EXEC = 4'd1} state_t;

   // Op codes 6..13 are array/data ops this block does not implement.
   localparam logic [3:0] OP_RST   = 4'd1;
   localparam logic [3:0] OP_WCFG0 = 4'd2;
   localparam logic [3:0] OP_RCFG0 = 4'd3;
   localparam logic [3:0] OP_WCFG1 = 4'd4;
   localparam logic [3:0] OP_RCFG1 = 4'd5;
   localparam logic [3:0] OP_CLEAR = 4'd14;
   localparam logic [3:0] OP_EXEC  = 4'd15;

   logic [39:0]           stage1, stage2;
   state_t                state_q, state_nxt;
   logic [EXEC_CNT_W-1:0] cnt_q, cnt_nxt;
   logic [23:0]           cfg0_q, cfg0_nxt, cfg1_q, cfg1_nxt;
   logic [31:0]           rdata_q, rdata_nxt, status_q, status_nxt;
   logic [7:0]            cmd_cnt_q, cmd_cnt_nxt;
   logic [3:0]            last_op_q, last_op_nxt;
   logic                  done_sticky_q, done_sticky_nxt;
   logic                  err_busy_q, err_busy_nxt;
   logic                  err_unsup_q, err_unsup_nxt;
   logic                  done_q, done_nxt;

   logic                  new_cmd, one_hot, fw_rst, busy_now;
   logic [14:0]           strobes;
   logic [23:0]           body;
   logic [3:0]            op;

   always_comb begin
      strobes = stage1[38:24];
      body    = stage1[23:0];
      new_cmd = stage1[39] && (stage1 != stage2);
      one_hot = (strobes & (strobes - 15'd1)) == 15'd0;
      busy_now = (state_q == EXEC);
      op = 4'd0;
      for (int k = 0; k < 15; k++) begin
         if (strobes[k]) op = 4'(k + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage1        <= '0;
         stage2        <= '0;
         state_q       <= IDLE;
         cnt_q         <= '0;
         cfg0_q        <= CFG_STATIC_0_RST;
         cfg1_q        <= CFG_STATIC_1_RST;
         rdata_q       <= '0;
         status_q      <= '0;
         cmd_cnt_q     <= '0;
         last_op_q     <= '0;
         done_sticky_q <= 1'b0;
         err_busy_q    <= 1'b0;
         err_unsup_q   <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         stage1        <= {fw_dev_id_enable, fw_op_code_strobes, sw_write24_0};
         stage2        <= stage1;
         state_q       <= state_nxt;
         cnt_q         <= cnt_nxt;
         cfg0_q        <= cfg0_nxt;
         cfg1_q        <= cfg1_nxt;
         rdata_q       <= rdata_nxt;
         status_q      <= status_nxt;
         cmd_cnt_q     <= cmd_cnt_nxt;
         last_op_q     <= last_op_nxt;
         done_sticky_q <= done_sticky_nxt;
         err_busy_q    <= err_busy_nxt;
         err_unsup_q   <= err_unsup_nxt;
         done_q        <= done_nxt;
      end
   end

   always_comb begin
      state_nxt       = state_q;
      cnt_nxt         = cnt_q;
      cfg0_nxt        = cfg0_q;
      cfg1_nxt        = cfg1_q;
      rdata_nxt       = rdata_q;
      cmd_cnt_nxt     = cmd_cnt_q;
      last_op_nxt     = last_op_q;
      done_sticky_nxt = done_sticky_q;
      err_busy_nxt    = err_busy_q;
      err_unsup_nxt   = err_unsup_q;
      done_nxt        = 1'b0;
      fw_rst          = 1'b0;

      if (new_cmd && strobes != 15'd0) begin
         if (!one_hot) begin
            err_unsup_nxt = 1'b1;
            cmd_cnt_nxt   = cmd_cnt_q + 8'd1;
            last_op_nxt   = 4'd0;
         end else if (op == OP_CLEAR) begin
            done_sticky_nxt = 1'b0;
            err_busy_nxt    = 1'b0;
            err_unsup_nxt   = 1'b0;
            cmd_cnt_nxt     = 8'd0;
            last_op_nxt     = op;
         end else begin
            cmd_cnt_nxt = cmd_cnt_q + 8'd1;
            last_op_nxt = op;
            case (op)
               OP_RST:   fw_rst = 1'b1;
               OP_WCFG0: if (busy_now) err_busy_nxt = 1'b1; else cfg0_nxt = body;
               OP_WCFG1: if (busy_now) err_busy_nxt = 1'b1; else cfg1_nxt = body;
               OP_RCFG0: rdata_nxt = {8'h00, cfg0_q};
               OP_RCFG1: rdata_nxt = {8'h00, cfg1_q};
               OP_EXEC: begin
                  if (busy_now) begin
                     err_busy_nxt = 1'b1;
                  end else if (body[EXEC_CNT_W-1:0] == '0) begin
                     done_nxt        = 1'b1;
                     done_sticky_nxt = 1'b1;
                  end else begin
                     cnt_nxt   = body[EXEC_CNT_W-1:0];
                     state_nxt = EXEC;
                  end
               end
               default:  err_unsup_nxt = 1'b1;
            endcase
         end
      end

      // Completion is evaluated after the command so a same-edge clear still records this done.
      if (busy_now) begin
         cnt_nxt = cnt_q - EXEC_CNT_W'(1);
         if (cnt_q == EXEC_CNT_W'(1)) begin
            state_nxt       = IDLE;
            done_nxt        = 1'b1;
            done_sticky_nxt = 1'b1;
         end
      end

      // Firmware reset leaves the command pipeline alone so a held reset word is not re-recognised.
      if (fw_rst) begin
         state_nxt       = IDLE;
         cnt_nxt         = '0;
         cfg0_nxt        = CFG_STATIC_0_RST;
         cfg1_nxt        = CFG_STATIC_1_RST;
         rdata_nxt       = '0;
         cmd_cnt_nxt     = '0;
         last_op_nxt     = '0;
         done_sticky_nxt = 1'b0;
         err_busy_nxt    = 1'b0;
         err_unsup_nxt   = 1'b0;
         done_nxt        = 1'b0;
      end

      status_nxt = {state_nxt, last_op_nxt, cmd_cnt_nxt, (state_nxt == EXEC),
                    done_sticky_nxt, err_busy_nxt, err_unsup_nxt, 12'h000};
   end

   always_comb begin
      fw_read_data32   = rdata_q;
      fw_read_status32 = status_q;
      fw_cfg_static_0  = cfg0_q;
      fw_cfg_static_1  = cfg1_q;
      fw_exec_busy     = (state_q == EXEC);
      fw_exec_done     = done_q;
   end

endmodule

// File: tb/tb_fw_cmd_responder.sv
// Bench for fw_cmd_responder: constant vector table, directed multi-cycle sequences and
// randomized commands checked every cycle against an event-time reference model.
module tb_fw_cmd_responder;

   localparam logic [23:0] P0 = 24'h111111;
   localparam logic [23:0] P1 = 24'h222222;
   localparam int          CW = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [14:0] strobes = '0;
   logic [23:0] body = '0;
   logic [31:0] read_data, read_status;
   logic [23:0] cfg0, cfg1;
   logic        busy, done;

   always #5 clk = ~clk;

   fw_cmd_responder #(
      .CFG_STATIC_0_RST(P0),
      .CFG_STATIC_1_RST(P1),
      .EXEC_CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .fw_dev_id_enable(en),
      .fw_op_code_strobes(strobes),
      .sw_write24_0(body),
      .fw_read_data32(read_data),
      .fw_read_status32(read_status),
      .fw_cfg_static_0(cfg0),
      .fw_cfg_static_1(cfg1),
      .fw_exec_busy(busy),
      .fw_exec_done(done)
   );

   int checks = 0;
   int failures = 0;
   int busy_seen = 0;
   int done_seen = 0;

   // Reference model: execution is tracked as the absolute edge number at which it ends.
   logic [39:0] m_s1 = '0, m_s2 = '0;
   logic [23:0] m_cfg0 = P0, m_cfg1 = P1;
   logic [31:0] m_rdata = '0;
   int          m_cnt = 0;
   logic [3:0]  m_lop = '0;
   bit          m_ds = 0, m_eb = 0, m_eu = 0, m_done = 0;
   longint      m_edge = 0, m_end = -1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_busy();
      return m_end >= m_edge;
   endfunction

   function automatic logic [31:0] m_status();
      bit b = m_busy();
      return {b ? 4'd1 : 4'd0, m_lop, 8'(m_cnt), b, m_ds, m_eb, m_eu, 12'h000};
   endfunction

   function automatic logic [14:0] opstr(int k);
      logic [14:0] r = '0;
      if (k > 0) r[k-1] = 1'b1;
      return r;
   endfunction

   task automatic m_fw_reset();
      m_cfg0 = P0; m_cfg1 = P1; m_rdata = '0; m_cnt = 0; m_lop = '0;
      m_ds = 0; m_eb = 0; m_eu = 0; m_end = -1;
   endtask

   task automatic model_edge();
      logic [14:0] s;
      logic [23:0] b;
      int op, n;
      bit busy_before, rst_cmd, nd;
      longint e;
      e = m_edge;
      m_edge++;
      nd = 0;
      rst_cmd = 0;
      if (reset) begin
         m_fw_reset();
         m_s1 = '0; m_s2 = '0; m_done = 0;
         return;
      end
      busy_before = (m_end >= e);
      s = m_s1[38:24];
      b = m_s1[23:0];
      if (m_s1[39] && m_s1 != m_s2 && s != 15'd0) begin
         if ($countones(s) > 1) begin
            m_eu = 1; m_cnt = (m_cnt + 1) % 256; m_lop = 4'd0;
         end else begin
            op = 0;
            for (int k = 0; k < 15; k++) if (s[k]) op = k + 1;
            if (op == 14) begin
               m_ds = 0; m_eb = 0; m_eu = 0; m_cnt = 0; m_lop = 4'd14;
            end else begin
               m_cnt = (m_cnt + 1) % 256;
               m_lop = 4'(op);
               case (op)
                  1: rst_cmd = 1;
                  2: if (busy_before) m_eb = 1; else m_cfg0 = b;
                  3: m_rdata = {8'h00, m_cfg0};
                  4: if (busy_before) m_eb = 1; else m_cfg1 = b;
                  5: m_rdata = {8'h00, m_cfg1};
                  15: begin
                     n = int'(b[CW-1:0]);
                     if (busy_before) m_eb = 1;
                     else if (n == 0) begin nd = 1; m_ds = 1; end
                     else m_end = e + n;
                  end
                  default: m_eu = 1;
               endcase
            end
         end
      end
      if (m_end == e) begin nd = 1; m_ds = 1; end
      if (rst_cmd) begin m_fw_reset(); nd = 0; end
      m_done = nd;
      m_s2 = m_s1;
      m_s1 = {en, strobes, body};
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("read_data", read_data, m_rdata);
      chk("status", read_status, m_status());
      chk("cfg0", {8'h0, cfg0}, {8'h0, m_cfg0});
      chk("cfg1", {8'h0, cfg1}, {8'h0, m_cfg1});
      chk("busy", {31'h0, busy}, {31'h0, m_busy()});
      chk("done", {31'h0, done}, {31'h0, m_done});
      if (busy) busy_seen++;
      if (done) done_seen++;
   endtask

   task automatic apply(bit e, logic [14:0] s, logic [23:0] b, int n);
      en = e; strobes = s; body = b;
      repeat (n) tick();
   endtask

   typedef struct {
      bit          e;
      logic [14:0] s;
      logic [23:0] b;
      int          hold;
      logic [23:0] x_cfg0, x_cfg1;
      logic [31:0] x_rdata;
      logic [7:0]  x_cnt;
      logic [3:0]  x_lop;
      logic [3:0]  x_flags;   // busy, done_sticky, err_busy, err_unsup
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{1, opstr(2),  24'hABCDEF, 3, 24'hABCDEF, P1, 32'h0,        8'd1, 4'd2,  4'b0000};
      tbl[1]  = '{1, opstr(3),  24'h000000, 3, 24'hABCDEF, P1, 32'h00ABCDEF, 8'd2, 4'd3,  4'b0000};
      tbl[2]  = '{1, opstr(2),  24'hABCDEF, 10, 24'hABCDEF, P1, 32'h00ABCDEF, 8'd3, 4'd2, 4'b0000};
      tbl[3]  = '{1, opstr(0),  24'h000000, 3, 24'hABCDEF, P1, 32'h00ABCDEF, 8'd3, 4'd2,  4'b0000};
      tbl[4]  = '{1, opstr(2),  24'hABCDEF, 3, 24'hABCDEF, P1, 32'h00ABCDEF, 8'd4, 4'd2,  4'b0000};
      tbl[5]  = '{0, opstr(4),  24'h123456, 3, 24'hABCDEF, P1, 32'h00ABCDEF, 8'd4, 4'd2,  4'b0000};
      tbl[6]  = '{1, opstr(4),  24'h123456, 3, 24'hABCDEF, 24'h123456, 32'h00ABCDEF, 8'd5, 4'd4, 4'b0000};
      tbl[7]  = '{1, opstr(5),  24'h000000, 3, 24'hABCDEF, 24'h123456, 32'h00123456, 8'd6, 4'd5, 4'b0000};
      tbl[8]  = '{1, opstr(7),  24'h000000, 3, 24'hABCDEF, 24'h123456, 32'h00123456, 8'd7, 4'd7, 4'b0001};
      tbl[9]  = '{1, opstr(14), 24'h000000, 3, 24'hABCDEF, 24'h123456, 32'h00123456, 8'd0, 4'd14, 4'b0000};
      tbl[10] = '{1, 15'h0003,  24'h000000, 3, 24'hABCDEF, 24'h123456, 32'h00123456, 8'd1, 4'd0, 4'b0001};
      tbl[11] = '{1, opstr(15), 24'hAB0000, 3, 24'hABCDEF, 24'h123456, 32'h00123456, 8'd2, 4'd15, 4'b0101};
      tbl[12] = '{1, opstr(1),  24'h000000, 3, P0, P1, 32'h0, 8'd0, 4'd0, 4'b0000};
      tbl[13] = '{1, opstr(2),  24'h000055, 3, 24'h000055, P1, 32'h0, 8'd1, 4'd2, 4'b0000};

      // Reset state
      repeat (2) tick();
      chk("rst_read_data", read_data, 32'h0);
      chk("rst_status", read_status, 32'h0);
      chk("rst_cfg0", {8'h0, cfg0}, {8'h0, P0});
      chk("rst_cfg1", {8'h0, cfg1}, {8'h0, P1});
      chk("rst_busy_done", {30'h0, busy, done}, 32'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].e, tbl[i].s, tbl[i].b, tbl[i].hold);
         chk($sformatf("vec%0d_cfg0", i), {8'h0, cfg0}, {8'h0, tbl[i].x_cfg0});
         chk($sformatf("vec%0d_cfg1", i), {8'h0, cfg1}, {8'h0, tbl[i].x_cfg1});
         chk($sformatf("vec%0d_rdata", i), read_data, tbl[i].x_rdata);
         chk($sformatf("vec%0d_status", i), read_status,
             {4'h0, tbl[i].x_lop, tbl[i].x_cnt, tbl[i].x_flags, 12'h000});
      end

      // Writes rejected and reads serviced while busy, then firmware reset aborts
      apply(1, opstr(4), 24'h5A5A5A, 3);
      apply(1, opstr(15), 24'h000064, 3);
      done_seen = 0;
      apply(1, opstr(4), 24'hBEEF00, 3);
      chk("busy_write_cfg1", {8'h0, cfg1}, 32'h005A5A5A);
      chk("busy_err_busy", {31'h0, read_status[13]}, 32'h1);
      apply(1, opstr(5), 24'h000000, 3);
      chk("busy_read_cfg1", read_data, 32'h005A5A5A);
      chk("busy_still", {31'h0, busy}, 32'h1);
      apply(1, opstr(1), 24'h000000, 3);
      chk("fwrst_busy", {31'h0, busy}, 32'h0);
      chk("fwrst_cfg0", {8'h0, cfg0}, {8'h0, P0});
      chk("fwrst_cfg1", {8'h0, cfg1}, {8'h0, P1});
      chk("fwrst_no_done", done_seen, 0);

      // Execute of 5: five busy cycles, one done pulse
      apply(1, opstr(0), 24'h000000, 2);
      busy_seen = 0;
      done_seen = 0;
      apply(1, opstr(15), 24'h000005, 12);
      chk("exec5_busy_cycles", busy_seen, 5);
      chk("exec5_done_pulses", done_seen, 1);
      chk("exec5_sticky", {31'h0, read_status[14]}, 32'h1);
      chk("exec5_state", {28'h0, read_status[31:28]}, 32'h0);

      // Hardware reset mid-execute, then the same word is recognised afresh
      apply(1, opstr(15), 24'h000032, 4);
      chk("hwrst_pre_busy", {31'h0, busy}, 32'h1);
      done_seen = 0;
      reset = 1'b1;
      repeat (2) tick();
      chk("hwrst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b0;
      repeat (3) tick();
      chk("hwrst_rerecognised", {31'h0, busy}, 32'h1);
      chk("hwrst_no_done", done_seen, 0);
      apply(1, opstr(1), 24'h000000, 3);

      // cmd_cnt wrap after 256 distinct commands
      apply(1, opstr(14), 24'h000000, 3);
      for (int i = 0; i < 256; i++) apply(1, opstr(2), 24'(i + 1), 1);
      apply(1, opstr(2), 24'd256, 3);
      chk("cnt_wrap", {24'h0, read_status[23:16]}, 32'h0);

      // Randomized commands against the model
      for (int i = 0; i < 600; i++) begin
         int r, hold;
         logic [14:0] s;
         logic [23:0] b;
         r = $urandom_range(0, 99);
         b = 24'($urandom);
         if (r < 3) s = opstr(1);
         else if (r < 8) s = 15'h0003 << $urandom_range(0, 13);
         else if (r < 15) s = opstr($urandom_range(6, 13));
         else if (r < 22) s = opstr(14);
         else if (r < 30) s = '0;
         else if (r < 55) begin
            s = opstr(15);
            b = {8'($urandom), 16'($urandom_range(0, 15))};
         end else s = opstr($urandom_range(2, 5));
         hold = $urandom_range(1, 4);
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
         apply($urandom_range(0, 9) != 0, s, b, hold);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
